// File: rtl/count_down_timer_if.sv
// ---------------------------------------------------------------------------
// count_down_timer_if : preset, pulse and count/status bundle for the timer
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface count_down_timer_if;
  logic [3:0] SET_M_HI;
  logic [3:0] SET_M_LO;
  logic [2:0] SET_S_HI;
  logic [3:0] SET_S_LO;
  logic       LOAD;
  logic       DEBOUNCED_START_STOP;
  logic       ONE_SEC_PULSE;
  logic       HALF_SEC_PULSE;
  logic [3:0] CNT_M_HI;
  logic [3:0] CNT_M_LO;
  logic [2:0] CNT_S_HI;
  logic [3:0] CNT_S_LO;
  logic       RUNNING;
  logic       ALARM;
  logic       ALARM_BLINK;

  modport slave (
    input  SET_M_HI, SET_M_LO, SET_S_HI, SET_S_LO,
    input  LOAD, DEBOUNCED_START_STOP, ONE_SEC_PULSE, HALF_SEC_PULSE,
    output CNT_M_HI, CNT_M_LO, CNT_S_HI, CNT_S_LO,
    output RUNNING, ALARM, ALARM_BLINK
  );

  modport master (
    output SET_M_HI, SET_M_LO, SET_S_HI, SET_S_LO,
    output LOAD, DEBOUNCED_START_STOP, ONE_SEC_PULSE, HALF_SEC_PULSE,
    input  CNT_M_HI, CNT_M_LO, CNT_S_HI, CNT_S_LO,
    input  RUNNING, ALARM, ALARM_BLINK
  );
endinterface

`default_nettype wire

// File: rtl/count_down_timer.sv
// ---------------------------------------------------------------------------
// count_down_timer : MM:SS BCD count-down timer with self-clearing alarm
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module count_down_timer #(
  parameter int ALARM_SECONDS = 60
) (
  input  wire logic          CLK,
  input  wire logic          RES_X,
  count_down_timer_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_ALARM = 2'd3
  } state_t;

  localparam logic [7:0] c_TMO_LIMIT = 8'(ALARM_SECONDS);

  state_t     r_state, w_state_nxt;
  logic [3:0] r_m_hi, r_m_lo, r_s_lo;
  logic [2:0] r_s_hi;
  logic [3:0] w_m_hi_nxt, w_m_lo_nxt, w_s_lo_nxt;
  logic [2:0] w_s_hi_nxt;
  logic       r_blink, w_blink_nxt;
  logic [6:0] r_tmo, w_tmo_nxt;

  logic [3:0] w_ld_m_hi, w_ld_m_lo, w_ld_s_lo;
  logic [2:0] w_ld_s_hi;
  logic [3:0] w_dec_m_hi, w_dec_m_lo, w_dec_s_lo;
  logic [2:0] w_dec_s_hi;
  logic       w_cnt_zero, w_dec_zero;
  logic [7:0] w_tmo_inc;
  logic       w_tmo_expire;

  // Out-of-range preset digits saturate to the largest legal digit
  assign w_ld_m_hi = (bus.SET_M_HI > 4'd9) ? 4'd9 : bus.SET_M_HI;
  assign w_ld_m_lo = (bus.SET_M_LO > 4'd9) ? 4'd9 : bus.SET_M_LO;
  assign w_ld_s_hi = (bus.SET_S_HI > 3'd5) ? 3'd5 : bus.SET_S_HI;
  assign w_ld_s_lo = (bus.SET_S_LO > 4'd9) ? 4'd9 : bus.SET_S_LO;

  assign w_cnt_zero = (r_m_hi == 4'd0) && (r_m_lo == 4'd0) &&
                      (r_s_hi == 3'd0) && (r_s_lo == 4'd0);

  always_comb begin
    w_dec_m_hi = r_m_hi;
    w_dec_m_lo = r_m_lo;
    w_dec_s_hi = r_s_hi;
    w_dec_s_lo = r_s_lo;
    if (r_s_lo != 4'd0) begin
      w_dec_s_lo = r_s_lo - 4'd1;
    end else begin
      w_dec_s_lo = 4'd9;
      if (r_s_hi != 3'd0) begin
        w_dec_s_hi = r_s_hi - 3'd1;
      end else begin
        w_dec_s_hi = 3'd5;
        if (r_m_lo != 4'd0) begin
          w_dec_m_lo = r_m_lo - 4'd1;
        end else begin
          w_dec_m_lo = 4'd9;
          w_dec_m_hi = r_m_hi - 4'd1;
        end
      end
    end
  end

  assign w_dec_zero = (w_dec_m_hi == 4'd0) && (w_dec_m_lo == 4'd0) &&
                      (w_dec_s_hi == 3'd0) && (w_dec_s_lo == 4'd0);

  assign w_tmo_inc    = {1'b0, r_tmo} + 8'd1;
  assign w_tmo_expire = (w_tmo_inc >= c_TMO_LIMIT);

  always_ff @(posedge CLK or negedge RES_X) begin
    if (!RES_X) begin
      r_state <= S_IDLE;
      r_m_hi  <= 4'd0;
      r_m_lo  <= 4'd0;
      r_s_hi  <= 3'd0;
      r_s_lo  <= 4'd0;
      r_blink <= 1'b0;
      r_tmo   <= 7'd0;
    end else begin
      r_state <= w_state_nxt;
      r_m_hi  <= w_m_hi_nxt;
      r_m_lo  <= w_m_lo_nxt;
      r_s_hi  <= w_s_hi_nxt;
      r_s_lo  <= w_s_lo_nxt;
      r_blink <= w_blink_nxt;
      r_tmo   <= w_tmo_nxt;
    end
  end

  // Priority inside every state: LOAD, then START_STOP, then the second tick
  always_comb begin
    w_state_nxt = r_state;
    w_m_hi_nxt  = r_m_hi;
    w_m_lo_nxt  = r_m_lo;
    w_s_hi_nxt  = r_s_hi;
    w_s_lo_nxt  = r_s_lo;
    w_blink_nxt = r_blink;
    w_tmo_nxt   = r_tmo;
    case (r_state)
      S_IDLE, S_PAUSE: begin
        if (bus.LOAD) begin
          w_m_hi_nxt  = w_ld_m_hi;
          w_m_lo_nxt  = w_ld_m_lo;
          w_s_hi_nxt  = w_ld_s_hi;
          w_s_lo_nxt  = w_ld_s_lo;
          w_state_nxt = S_IDLE;
        end else if (bus.DEBOUNCED_START_STOP && !w_cnt_zero) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (bus.DEBOUNCED_START_STOP) begin
          w_state_nxt = S_PAUSE;
        end else if (bus.ONE_SEC_PULSE) begin
          w_m_hi_nxt = w_dec_m_hi;
          w_m_lo_nxt = w_dec_m_lo;
          w_s_hi_nxt = w_dec_s_hi;
          w_s_lo_nxt = w_dec_s_lo;
          if (w_dec_zero) begin
            w_state_nxt = S_ALARM;
          end
        end
      end
      S_ALARM: begin
        if (bus.LOAD) begin
          w_m_hi_nxt  = w_ld_m_hi;
          w_m_lo_nxt  = w_ld_m_lo;
          w_s_hi_nxt  = w_ld_s_hi;
          w_s_lo_nxt  = w_ld_s_lo;
          w_state_nxt = S_IDLE;
          w_blink_nxt = 1'b0;
          w_tmo_nxt   = 7'd0;
        end else if (bus.DEBOUNCED_START_STOP ||
                     (bus.ONE_SEC_PULSE && w_tmo_expire)) begin
          w_state_nxt = S_IDLE;
          w_blink_nxt = 1'b0;
          w_tmo_nxt   = 7'd0;
        end else begin
          if (bus.ONE_SEC_PULSE) begin
            w_tmo_nxt = w_tmo_inc[6:0];
          end
          if (bus.HALF_SEC_PULSE) begin
            w_blink_nxt = ~r_blink;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign bus.CNT_M_HI    = r_m_hi;
  assign bus.CNT_M_LO    = r_m_lo;
  assign bus.CNT_S_HI    = r_s_hi;
  assign bus.CNT_S_LO    = r_s_lo;
  assign bus.RUNNING     = (r_state == S_RUN);
  assign bus.ALARM       = (r_state == S_ALARM);
  assign bus.ALARM_BLINK = r_blink;

endmodule

`default_nettype wire

// File: doc/count_down_timer.md
COUNT_DOWN_TIMER -- requirements
Module: count_down_timer

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset, named CLK and RES_X.
REQ-002 Parameter ALARM_SECONDS SHALL default to 60; it is the number of ONE_SEC_PULSE pulses after which the alarm self-clears.
REQ-003 CLK  input  1  system clock; all state updates on its rising edge.
REQ-004 RES_X  input  1  asynchronous active-low reset.
REQ-005 SET_M_HI  input  4  preset minute tens, BCD.
REQ-006 SET_M_LO  input  4  preset minute units, BCD.
REQ-007 SET_S_HI  input  3  preset second tens, 0-5.
REQ-008 SET_S_LO  input  4  preset second units, BCD.
REQ-009 LOAD  input  1  one-cycle pulse; copy the SET_* digits into the count.
REQ-010 DEBOUNCED_START_STOP  input  1  one-cycle pulse; start/pause/acknowledge.
REQ-011 ONE_SEC_PULSE  input  1  one-cycle pulse, once per second.
REQ-012 HALF_SEC_PULSE  input  1  one-cycle pulse, once per 0.5 s.
REQ-013 CNT_M_HI, CNT_M_LO, CNT_S_LO  output  4 each  current count digits, BCD, registered.
REQ-014 CNT_S_HI  output  3  current second tens digit, registered.
REQ-015 RUNNING  output  1  high in RUN state only.
REQ-016 ALARM  output  1  high in ALARM state only.
REQ-017 ALARM_BLINK  output  1  blink drive; toggles in ALARM and is 0 otherwise.

Function
REQ-018 The FSM SHALL have the states IDLE, RUN, PAUSE and ALARM; the default after reset is IDLE.
REQ-019 LOAD SHALL be accepted in IDLE, PAUSE and ALARM.
- It loads the digits on the same edge.
- The next state is IDLE.
- In RUN, LOAD is ignored.
REQ-020 Load clamping SHALL apply per digit.
- M_HI, M_LO or S_LO greater than 9 loads as 9.
- S_HI greater than 5 loads as 5.
REQ-021 In IDLE or PAUSE, DEBOUNCED_START_STOP SHALL go to RUN if the count is nonzero.
- If the count is 00:00, the state does not change.
REQ-022 In RUN, DEBOUNCED_START_STOP SHALL go to PAUSE.
- No decrement happens that cycle, even if ONE_SEC_PULSE is also high.
REQ-023 In RUN, ONE_SEC_PULSE SHALL decrement the count by one second, visible on the next edge (1-cycle latency).
- S_LO counts 0 to 9 with a borrow.
- S_HI counts 0 to 5 with a borrow, only when S_LO borrows.
- M_LO counts 0 to 9 with a borrow, only when the seconds borrow.
- M_HI decrements only when M_LO borrows.
REQ-024 When a decrement produces 00:00, the count SHALL become 00:00 and the state ALARM on the same edge.
- The count never wraps below 00:00.
REQ-025 In ALARM, the count SHALL hold at 00:00.
- ALARM_BLINK toggles on every HALF_SEC_PULSE.
- A 7-bit timeout counter increments on every ONE_SEC_PULSE.
REQ-026 ALARM SHALL exit to IDLE on whichever of these comes first:
- DEBOUNCED_START_STOP;
- LOAD;
- the timeout counter reaching ALARM_SECONDS.
REQ-027 On any exit from ALARM, ALARM_BLINK and the timeout counter SHALL clear.
REQ-028 Same-cycle priority SHALL be LOAD > DEBOUNCED_START_STOP > ONE_SEC_PULSE.
- A LOAD in IDLE with START_STOP in the same cycle loads and stays IDLE.
REQ-029 The count SHALL change only through LOAD or a RUN decrement.
- PAUSE and IDLE ignore ONE_SEC_PULSE.
REQ-030 The maximum count is 99:59; 99:59 SHALL decrement correctly to 99:58.

Reset
REQ-031 While RES_X is low, the following SHALL hold immediately, regardless of CLK:
- all digits are 0;
- the state is IDLE;
- RUNNING, ALARM and ALARM_BLINK are 0;
- the timeout counter is 0.
REQ-032 Reset asserted in any state, including mid-RUN or ALARM, SHALL abort the operation with no residual state.

Verification
REQ-033 Load 01:00, start, apply one ONE_SEC_PULSE -> 00:59 the next cycle, RUNNING=1.
REQ-034 Load 00:02, start, apply two pulses -> 00:01, then 00:00 with ALARM=1 and RUNNING=0 on the same edge; further pulses leave 00:00.
REQ-035 Load 10:00, start, apply one pulse -> 09:59; START_STOP together with a ONE_SEC_PULSE -> PAUSE, count stays 09:59; further pulses do not change it; START_STOP -> RUN resumes from 09:59.
REQ-036 Load with SET = 4'hC, 4'hF, 3'h7, 4'hA (M_HI, M_LO, S_HI, S_LO) -> count 99:59; one RUN pulse -> 99:58.
REQ-037 In ALARM:
- four HALF_SEC_PULSEs -> ALARM_BLINK toggles 1, 0, 1, 0;
- with ALARM_SECONDS=3, three ONE_SEC_PULSEs -> IDLE, ALARM=0;
- re-enter ALARM, LOAD 05:00 -> IDLE, count 05:00.
REQ-038 Start from 00:00 -> stays IDLE; RES_X low mid-RUN at 03:27 -> 00:00, IDLE, all flags 0 without a clock edge.
